// File: rtl/accel_bus_window_decoder.sv
// Memory-mapped window decoder: grants CPU accesses to NUM_REGS word registers,
// drives registered select/strobes, waits for per-register ready and returns a one-cycle response.
module accel_bus_window_decoder #(
  parameter int                        ADDR_BUS_WIDTH = 32,
  parameter int                        DATA_WIDTH     = 32,
  parameter logic [ADDR_BUS_WIDTH-1:0] BASE_ADDRESS   = 32'h1A100000,
  parameter int                        NUM_REGS       = 4,
  parameter logic [NUM_REGS-1:0]       READ_MASK      = '1,
  parameter logic [NUM_REGS-1:0]       WRITE_MASK     = '1,
  parameter int                        TIMEOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_BUS_WIDTH-1:0]      cpu_addr,
  input  logic                           cpu_read_en,
  input  logic                           cpu_write_en,
  input  logic [DATA_WIDTH-1:0]          cpu_wdata,
  output logic                           cpu_gnt,
  output logic                           cpu_rvalid,
  output logic [DATA_WIDTH-1:0]          cpu_rdata,
  output logic                           cpu_err,
  output logic [NUM_REGS-1:0]            reg_sel,
  output logic                           reg_we,
  output logic                           reg_re,
  output logic [DATA_WIDTH-1:0]          reg_wdata,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_rdata,
  input  logic [NUM_REGS-1:0]            reg_ready
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W:0] TIMEOUT_LIMIT = (CNT_W + 1)'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx_reg;
  logic [CNT_W-1:0]    cnt_reg;

  logic                req;
  logic                hit;
  logic                legal;
  logic [IDX_W-1:0]    idx;
  logic [NUM_REGS-1:0] idx_onehot;
  logic                sel_ready;
  logic                timeout_hit;
  logic [DATA_WIDTH-1:0] sel_rdata;

  assign req = cpu_read_en | cpu_write_en;
  assign hit = (cpu_addr[ADDR_BUS_WIDTH-1:IDX_W+2] == BASE_ADDRESS[ADDR_BUS_WIDTH-1:IDX_W+2]);
  assign idx = cpu_addr[IDX_W+1:2];

  // Exactly one direction, and that direction must be permitted for the addressed register.
  assign legal = (cpu_read_en ^ cpu_write_en) &&
                 (cpu_read_en ? READ_MASK[idx] : WRITE_MASK[idx]);

  assign cpu_gnt = (state == IDLE) && req && hit;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
    assign idx_onehot[gi] = (idx == IDX_W'(gi));
  end

  assign sel_ready = reg_ready[idx_reg];
  assign sel_rdata = reg_rdata[idx_reg*DATA_WIDTH +: DATA_WIDTH];

  // A zero limit disables the timeout entirely.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (({1'b0, cnt_reg} + 1'b1) == TIMEOUT_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx_reg    <= '0;
      cnt_reg    <= '0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      cpu_err    <= 1'b0;
      reg_sel    <= '0;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      reg_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cpu_rvalid <= 1'b0;
          cpu_rdata  <= '0;
          cpu_err    <= 1'b0;
          if (cpu_gnt) begin
            idx_reg <= idx;
            cnt_reg <= '0;
            if (legal) begin
              state     <= ACCESS;
              reg_sel   <= idx_onehot;
              reg_we    <= cpu_write_en;
              reg_re    <= cpu_read_en;
              reg_wdata <= cpu_wdata;
            end else begin
              // Illegal access answers immediately and never touches the register file.
              state      <= RESP;
              cpu_rvalid <= 1'b1;
              cpu_err    <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (sel_ready) begin
            state      <= RESP;
            cpu_rvalid <= 1'b1;
            cpu_err    <= 1'b0;
            cpu_rdata  <= reg_re ? sel_rdata : '0;
            reg_sel    <= '0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
          end else if (timeout_hit) begin
            state      <= RESP;
            cpu_rvalid <= 1'b1;
            cpu_err    <= 1'b1;
            cpu_rdata  <= '0;
            reg_sel    <= '0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          cpu_rvalid <= 1'b0;
          cpu_rdata  <= '0;
          cpu_err    <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accel_bus_window_decoder.sv
// Bench for accel_bus_window_decoder: directed cases plus randomized accesses
// checked against a transaction-level latency/permission model.
module tb_accel_bus_window_decoder;

  localparam logic [31:0] BASE  = 32'h1A100000;
  localparam logic [3:0]  RMASK = 4'b0111;
  localparam logic [3:0]  WMASK = 4'b1011;
  localparam int          TMO   = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  cpu_addr;
  logic         cpu_read_en;
  logic         cpu_write_en;
  logic [31:0]  cpu_wdata;
  logic         cpu_gnt;
  logic         cpu_rvalid;
  logic [31:0]  cpu_rdata;
  logic         cpu_err;
  logic [3:0]   reg_sel;
  logic         reg_we;
  logic         reg_re;
  logic [31:0]  reg_wdata;
  logic [127:0] reg_rdata;
  logic [3:0]   reg_ready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  accel_bus_window_decoder #(
    .ADDR_BUS_WIDTH(32),
    .DATA_WIDTH(32),
    .BASE_ADDRESS(BASE),
    .NUM_REGS(4),
    .READ_MASK(RMASK),
    .WRITE_MASK(WMASK),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cpu_addr(cpu_addr),
    .cpu_read_en(cpu_read_en),
    .cpu_write_en(cpu_write_en),
    .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .cpu_err(cpu_err),
    .reg_sel(reg_sel),
    .reg_we(reg_we),
    .reg_re(reg_re),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .reg_ready(reg_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic randomize_bus();
    reg_rdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One CPU access; d = number of ACCESS cycles before the peripheral raises ready.
  task automatic txn(input logic [31:0] addr, input logic rd, input logic wr,
                     input logic [31:0] wdata, input int d);
    logic        hit;
    logic        legal;
    logic        err;
    logic [3:0]  oh;
    logic [31:0] exp_rdata;
    int          idx;
    int          n;
    hit   = (addr[31:4] == BASE[31:4]);
    idx   = int'(addr[3:2]);
    oh    = 4'b0001 << idx;
    legal = (rd != wr) && (rd ? RMASK[idx] : WMASK[idx]);
    if (!legal) begin
      n = 0; err = 1'b1;
    end else if (d >= TMO) begin
      n = TMO; err = 1'b1;
    end else begin
      n = d + 1; err = 1'b0;
    end
    exp_rdata = (legal && rd && !err) ? reg_rdata[idx*32 +: 32] : 32'h0;

    cpu_addr = addr; cpu_read_en = rd; cpu_write_en = wr; cpu_wdata = wdata;
    #1;
    check("gnt", {31'b0, cpu_gnt}, {31'b0, hit});
    if (!hit) begin
      for (int k = 0; k < 10; k++) begin
        cycle();
        check("miss_quiet", {cpu_gnt, cpu_rvalid, reg_we, reg_re, reg_sel}, 32'h0);
      end
      cpu_read_en = 1'b0; cpu_write_en = 1'b0;
      $display("txn addr=%h rd=%0d wr=%0d miss", addr, rd, wr);
      return;
    end
    cycle();
    cpu_wdata = $urandom;
    for (int k = 1; k <= n + 1; k++) begin
      #1;
      check("gnt_busy", {31'b0, cpu_gnt}, 32'h0);
      if (k <= n) begin
        check("access_sel", {reg_we, reg_re, cpu_rvalid, reg_sel}, {wr, rd, 1'b0, oh});
        if (wr) check("access_wdata", reg_wdata, wdata);
        reg_ready = (k > d) ? oh : ~oh;
      end else begin
        check("resp", {cpu_rvalid, cpu_err, reg_we, reg_re, reg_sel}, {1'b1, err, 6'b0});
        check("resp_rdata", cpu_rdata, exp_rdata);
        cpu_read_en = 1'b0; cpu_write_en = 1'b0;
        reg_ready = 4'b0;
      end
      cycle();
    end
    #1;
    check("after_resp", {cpu_rvalid, cpu_err}, 32'h0);
    check("after_rdata", cpu_rdata, 32'h0);
    $display("txn addr=%h rd=%0d wr=%0d wait=%0d n=%0d err=%0d rdata=%h",
             addr, rd, wr, d, n, err, exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cpu_addr = '0; cpu_read_en = 1'b0; cpu_write_en = 1'b0; cpu_wdata = '0;
    reg_rdata = '0; reg_ready = '0;
    cycle();
    cycle();
    check("reset_ctrl", {cpu_gnt, cpu_rvalid, cpu_err, reg_we, reg_re, reg_sel}, 32'h0);
    check("reset_data", cpu_rdata | reg_wdata, 32'h0);
    rst_n = 1'b1;
    cycle();

    // Read reg 2 with immediate ready.
    randomize_bus();
    reg_rdata[64 +: 32] = 32'hCAFE0002;
    txn(BASE + 32'h8, 1'b1, 1'b0, 32'h0, 0);
    // Write reg 1 with three wait cycles.
    txn(32'h1A100004, 1'b0, 1'b1, 32'h12345678, 3);
    // Outside the window.
    txn(32'h1A100020, 1'b1, 1'b0, 32'h0, 0);
    // Permission errors: write to reg 2, read of reg 3, and both enables together.
    txn(BASE + 32'h8, 1'b0, 1'b1, 32'hDEADBEEF, 0);
    txn(BASE + 32'hC, 1'b1, 1'b0, 32'h0, 0);
    txn(BASE + 32'h0, 1'b1, 1'b1, 32'h55AA55AA, 0);
    // Timeout and the last cycle where ready still wins.
    randomize_bus();
    txn(BASE + 32'h0, 1'b1, 1'b0, 32'h0, 1000);
    txn(BASE + 32'h0, 1'b1, 1'b0, 32'h0, TMO - 1);
    txn(BASE + 32'hC, 1'b0, 1'b1, 32'hA5A5A5A5, TMO);

    // Reset pulse in the middle of an access.
    randomize_bus();
    cpu_addr = BASE; cpu_read_en = 1'b1;
    #1;
    check("rst_gnt", {31'b0, cpu_gnt}, 32'h1);
    cycle();
    cpu_read_en = 1'b0;
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", {cpu_rvalid, reg_we, reg_re, reg_sel}, 32'h0);
    cycle();
    cycle();
    check("rst_no_resp", {31'b0, cpu_rvalid}, 32'h0);
    rst_n = 1'b1;
    cycle();
    check("rst_release", {cpu_rvalid, reg_re, reg_sel}, 32'h0);
    $display("txn reset during access dropped");
    txn(BASE + 32'h8, 1'b1, 1'b0, 32'h0, 2);

    // Randomized accesses.
    for (int t = 0; t < 30; t++) begin
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      int          m;
      int          d;
      randomize_bus();
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      else addr = BASE | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      m  = $urandom_range(0, 5);
      rd = (m <= 2) || (m == 5);
      wr = (m >= 3);
      d  = ($urandom_range(0, 4) == 0) ? $urandom_range(TMO - 1, TMO + 1) : $urandom_range(0, 4);
      txn(addr, rd, wr, $urandom, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
